// File: rtl/ukf_pkg.sv
// ukf_pkg: shared phase encoding and per-phase op bookkeeping for the UKF sequencer.
package ukf_pkg;
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_GEN_SIGMA  = 4'd1,
    S_PROPAGATE  = 4'd2,
    S_MEAN_COV   = 4'd3,
    S_MEAS_TRANS = 4'd4,
    S_INNOVATION = 4'd5,
    S_UPDATE     = 4'd6,
    S_DONE       = 4'd7,
    S_ERROR      = 4'd8
  } ukf_state_t;
  localparam logic [3:0] OP_GEN_SIGMA  = 4'd1;
  localparam logic [3:0] OP_PROPAGATE  = 4'd2;
  localparam logic [3:0] OP_MEAN_COV   = 4'd3;
  localparam logic [3:0] OP_MEAS_TRANS = 4'd4;
  localparam logic [3:0] OP_INNOVATION = 4'd5;
  localparam logic [3:0] OP_UPDATE     = 4'd6;
  function automatic int ops_per_phase(ukf_state_t s, int n_sigma);
    return (s == S_GEN_SIGMA || s == S_PROPAGATE || s == S_MEAS_TRANS) ? n_sigma :
           (s == S_MEAN_COV || s == S_INNOVATION || s == S_UPDATE) ? 1 : 0;
  endfunction
  function automatic ukf_state_t next_phase(ukf_state_t s, logic mv);
    return s == S_GEN_SIGMA  ? S_PROPAGATE :
           s == S_PROPAGATE  ? S_MEAN_COV :
           s == S_MEAN_COV   ? (mv ? S_MEAS_TRANS : S_DONE) :
           s == S_MEAS_TRANS ? S_INNOVATION :
           s == S_INNOVATION ? S_UPDATE : S_DONE;
  endfunction
endpackage

// File: rtl/ukf_op_issuer.sv
// ukf_op_issuer: req/ack/done handshake for one datapath op with a per-op timeout counter.
module ukf_op_issuer #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic            flush,
  input  logic [TO_W-1:0] timeout_lim,
  input  logic            op_ack,
  input  logic            op_done,
  output logic            op_req,
  output logic            complete,
  output logic            timeout
);
  logic req_q, wait_q, active;
  logic [TO_W-1:0] to_q;
  logic [TO_W:0] to_nx;
  assign active   = req_q | wait_q;
  assign complete = ((req_q & op_ack) | wait_q) & op_done;
  assign to_nx    = {1'b0, to_q} + 1'b1;
  // fires on the cycle the counter would reach the limit, so err shows lim cycles after req
  assign timeout  = active & ~complete & (timeout_lim != '0) & (to_nx >= {1'b0, timeout_lim});
  assign op_req   = req_q;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
      to_q   <= '0;
    end else if (issue) begin
      req_q  <= 1'b1;
      wait_q <= 1'b0;
      to_q   <= '0;
    end else begin
      req_q  <= req_q & ~op_ack;
      wait_q <= ((req_q & op_ack) | wait_q) & ~op_done;
      to_q   <= active ? to_nx[TO_W-1:0] : to_q;
    end
  end
endmodule

// File: rtl/ukf_seq_ctrl.sv
// ukf_seq_ctrl: predict/update phase sequencer issuing indexed datapath ops with timeout, abort and cycle report.
module ukf_seq_ctrl
  import ukf_pkg::*;
#(
  parameter int N_STATE = 6,
  parameter int N_SIGMA = 2*N_STATE+1,
  parameter int IDX_W   = $clog2(N_SIGMA),
  parameter int TO_W    = 16,
  parameter int CYC_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             meas_valid,
  input  logic             abort,
  input  logic [TO_W-1:0]  timeout_lim,
  output logic             op_req,
  output logic [3:0]       op_code,
  output logic [IDX_W-1:0] op_idx,
  input  logic             op_ack,
  input  logic             op_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cyc_count,
  output logic [3:0]       state_dbg
);
  ukf_state_t state_q, nxt;
  logic [IDX_W-1:0] idx_q;
  logic mv_q, op_phase, last, issue, complete, timeout;
  logic [CYC_W-1:0] cnt_q, cyc_q, cnt_inc;
  always_comb begin
    op_phase = ops_per_phase(state_q, N_SIGMA) != 0;
    last     = int'(idx_q) == ops_per_phase(state_q, N_SIGMA) - 1;
    nxt      = next_phase(state_q, mv_q);
    issue    = ~abort & ((state_q == S_IDLE & start) | (op_phase & complete & ~(last & nxt == S_DONE)));
    cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
  end
  ukf_op_issuer #(.TO_W(TO_W)) u_issuer (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .flush       (abort | timeout),
    .timeout_lim (timeout_lim),
    .op_ack      (op_ack),
    .op_done     (op_done),
    .op_req      (op_req),
    .complete    (complete),
    .timeout     (timeout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mv_q    <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        state_q <= S_GEN_SIGMA;
        idx_q   <= '0;
        mv_q    <= meas_valid;
        cnt_q   <= '0;
      end
    end else begin
      cnt_q <= cnt_inc;
      if (state_q == S_DONE) begin
        state_q <= S_IDLE;
        cyc_q   <= cnt_inc;
      end else if (timeout) begin
        state_q <= S_ERROR;
      end else if (complete) begin
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (last) state_q <= nxt;
      end
    end
  end
  assign op_code   = state_q;
  assign op_idx    = idx_q;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = state_q == S_ERROR;
  assign cyc_count = cyc_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_ukf_seq_ctrl.sv
// tb_ukf_seq_ctrl: scoreboard bench with a randomized-latency datapath model and a phase-list reference.
module tb_ukf_seq_ctrl;
  localparam int N_STATE = 6;
  localparam int N_SIGMA = 2*N_STATE+1;
  localparam int IDX_W   = $clog2(N_SIGMA);
  localparam int TO_W    = 16;
  localparam int CYC_W   = 32;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, meas_valid = 1'b0, abort = 1'b0;
  logic op_ack = 1'b0, op_done = 1'b0;
  logic [TO_W-1:0] timeout_lim = '0;
  logic op_req, busy, done, err;
  logic [3:0] op_code, state_dbg;
  logic [IDX_W-1:0] op_idx;
  logic [CYC_W-1:0] cyc_count;

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, req_start = 0, done_cnt = 0, hold = 0;
  int a_dly = 0, d_dly = 0;
  bit hang_en = 1'b0;

  typedef struct {int code; int idx;} op_t;
  op_t exp_ops[$];
  int exp_lat[$];

  ukf_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .meas_valid(meas_valid), .abort(abort),
    .timeout_lim(timeout_lim), .op_req(op_req), .op_code(op_code), .op_idx(op_idx),
    .op_ack(op_ack), .op_done(op_done), .busy(busy), .done(done), .err(err),
    .cyc_count(cyc_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Datapath: ack a_dly cycles after req appears, done d_dly cycles after ack.
  initial begin : drv
    int wcnt;
    bit pend, hung;
    wcnt = 0; pend = 0; hung = 0;
    forever begin
      @(posedge clk); #1;
      op_ack = 1'b0;
      op_done = 1'b0;
      if (rst || abort) begin
        pend = 0; hung = 0; wcnt = 0;
      end else if (op_req && !pend) begin
        if (wcnt == a_dly) begin
          op_ack = 1'b1;
          wcnt = 0;
          hung = hang_en && op_code == 4'd2 && op_idx == 2;
          if (d_dly == 0 && !hung) op_done = 1'b1;
          else pend = 1;
        end else wcnt++;
      end else if (pend && !hung) begin
        if (wcnt == d_dly - 1) begin
          op_done = 1'b1; pend = 0; wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // Monitor: pops expected ops on each accepted request and expected latency on each done.
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [3:0] prev_code = '0;
  logic [IDX_W-1:0] prev_idx = '0;
  bit cyc_pend = 0;
  int cyc_exp = 0;
  always @(negedge clk) begin : mon
    op_t e;
    int l;
    if (rst || abort) begin
      hold = 0; prev_req = 1'b0; cyc_pend = 0;
    end else begin
      if (cyc_pend) begin
        chk("cyc_count", cyc_count, cyc_exp);
        cyc_pend = 0;
      end
      if (op_req) begin
        if (prev_req && !prev_ack) begin
          chk("req_code_stable", op_code, prev_code);
          chk("req_idx_stable", op_idx, prev_idx);
        end else req_start = cyc;
        hold++;
        if (op_ack) begin
          if (exp_ops.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_op code=%0d idx=%0d expected none", op_code, op_idx);
          end else begin
            e = exp_ops.pop_front();
            chk("op_code", op_code, e.code);
            chk("op_idx", op_idx, e.idx);
          end
          chk("req_hold", hold, a_dly + 1);
          hold = 0;
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_lat.size() == 0) fail_now("unexpected_done");
        else begin
          l = exp_lat.pop_front();
          chk("done_latency", cyc - start_cyc, l);
          cyc_pend = 1;
          cyc_exp = l;
        end
      end
      prev_req = op_req; prev_ack = op_ack; prev_code = op_code; prev_idx = op_idx;
    end
  end

  task automatic push_ops(bit mv, int max);
    int n = 0;
    for (int p = 1; p <= (mv ? 6 : 3); p++) begin
      int cnt;
      cnt = (p == 3 || p >= 5) ? 1 : N_SIGMA;
      for (int i = 0; i < cnt; i++)
        if (n < max) begin
          exp_ops.push_back('{p, i});
          n++;
        end
    end
  endtask

  task automatic issue_start(bit mv);
    @(negedge clk); #2;
    start = 1'b1; meas_valid = mv; start_cyc = cyc;
    @(negedge clk); #2;
    start = 1'b0; meas_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_abort();
    @(negedge clk); #2 abort = 1'b1;
    @(negedge clk); #2;
  endtask

  task automatic run_iter(bit mv, int a, int d);
    int ops, n0, k;
    a_dly = a; d_dly = d;
    ops = mv ? 3*N_SIGMA+3 : 2*N_SIGMA+1;
    push_ops(mv, ops);
    exp_lat.push_back(ops*(a+d+1)+1);
    n0 = done_cnt;
    issue_start(mv);
    k = 0;
    while (done_cnt == n0 && k < 2000) begin @(negedge clk); k++; end
    if (done_cnt == n0) fail_now("done_wait_expired");
    repeat (2) @(negedge clk);
    #2;
    chk("idle_state", state_dbg, 0);
    chk("ops_drained", exp_ops.size(), 0);
    exp_ops.delete(); exp_lat.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, n0;
    logic [CYC_W-1:0] saved;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_state", state_dbg, 0);
    chk("rst_req", {op_req, op_code, op_idx}, 0);
    chk("rst_flags", {busy, done, err}, 0);
    chk("rst_cyc", cyc_count, 0);
    rst = 1'b0;

    run_iter(0, 0, 0);
    run_iter(1, 0, 0);
    run_iter(0, 3, 5);
    run_iter(1, 3, 5);
    for (int r = 0; r < 4; r++) begin
      timeout_lim = $urandom_range(0, 1) ? 16'd20 : 16'd0;
      run_iter(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    // Timeout on PROPAGATE idx 2
    timeout_lim = 16'd4; a_dly = 0; d_dly = 0; hang_en = 1'b1;
    push_ops(0, N_SIGMA + 3);
    n0 = done_cnt;
    issue_start(0);
    k = 0;
    while (!err && k < 300) begin @(negedge clk); #2; k++; end
    chk("err_set", err, 1);
    chk("err_delay", cyc - req_start, 4);
    chk("err_state", state_dbg, 8);
    chk("err_req", op_req, 0);
    start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("err_hold_state", state_dbg, 8);
    chk("err_no_done", done_cnt, n0);
    pulse_abort();
    chk("abort_err_state", state_dbg, 0);
    chk("abort_err_flags", {err, busy, op_req}, 0);
    abort = 1'b0;
    chk("to_ops_drained", exp_ops.size(), 0);

    // Same hang with timeout disabled: waits indefinitely
    timeout_lim = '0;
    push_ops(0, N_SIGMA + 3);
    issue_start(0);
    repeat (80) @(negedge clk);
    #2;
    chk("nolim_state", state_dbg, 2);
    chk("nolim_flags", {err, busy, op_req}, 3'b010);
    pulse_abort();
    abort = 1'b0;
    hang_en = 1'b0;
    chk("nolim_ops_drained", exp_ops.size(), 0);
    exp_ops.delete();

    // Abort at MEAS_TRANS idx 5
    saved = cyc_count;
    a_dly = 0; d_dly = 0;
    push_ops(1, 2*N_SIGMA + 1 + 6);
    n0 = done_cnt;
    issue_start(1);
    k = 0;
    while (!(op_req && op_code == 4'd4 && op_idx == 5) && k < 300) begin @(negedge clk); #2; k++; end
    if (k >= 300) fail_now("meas_idx5_wait_expired");
    abort = 1'b1;
    @(negedge clk); #2;
    chk("abort_state", state_dbg, 0);
    chk("abort_flags", {op_req, busy, done}, 0);
    chk("abort_cyc_kept", cyc_count, saved);
    abort = 1'b0;
    chk("abort_ops_drained", exp_ops.size(), 0);
    chk("abort_no_done", done_cnt, n0);
    exp_ops.delete();
    run_iter(1, 0, 0);

    // Start while busy ignored, then rst during UPDATE
    push_ops(1, 3*N_SIGMA + 3);
    n0 = done_cnt;
    issue_start(1);
    repeat (5) @(negedge clk);
    #2 start = 1'b1; meas_valid = 1'b0;
    @(negedge clk); #2 start = 1'b0;
    k = 0;
    while (!(op_req && op_code == 4'd6) && k < 300) begin @(negedge clk); #2; k++; end
    if (k >= 300) fail_now("update_wait_expired");
    rst = 1'b1;
    @(negedge clk); #2;
    chk("rst_mid_state", state_dbg, 0);
    chk("rst_mid_req", {op_req, op_code, op_idx}, 0);
    chk("rst_mid_flags", {busy, done, err}, 0);
    chk("rst_mid_cyc", cyc_count, 0);
    chk("rst_mid_ops_drained", exp_ops.size(), 0);
    chk("rst_mid_no_done", done_cnt, n0);
    exp_ops.delete();
    rst = 1'b0;
    run_iter(0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
